// File: rtl/quant_zigzag_pkg.sv
// ---------------------------------------------------------------------------
// quant_zigzag_pkg
// Shared codec definitions for the quantizer / zigzag serializer:
//   - default datapath widths (coefficient, fraction, reciprocal, output)
//   - the controller state enum
//   - ZIGZAG_ROW / ZIGZAG_COL: JPEG zigzag scan order, entry k gives the
//     [row][col] position of zigzag index k
// No ports (package).
// ---------------------------------------------------------------------------
package quant_zigzag_pkg;

    localparam int QZ_COEF_W          = 54;
    localparam int QZ_COEF_FRAC_BITS  = 24;
    localparam int QZ_RECIP_W         = 17;
    localparam int QZ_OUT_W           = 12;
    // Reciprocals are round(2^16 / Q), so they carry 16 fractional bits.
    localparam int QZ_RECIP_FRAC_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } qz_state_e;

    // One line per anti-diagonal of the 8x8 block.
    localparam int ZIGZAG_ROW [64] = '{
        0,
        0, 1,
        2, 1, 0,
        0, 1, 2, 3,
        4, 3, 2, 1, 0,
        0, 1, 2, 3, 4, 5,
        6, 5, 4, 3, 2, 1, 0,
        0, 1, 2, 3, 4, 5, 6, 7,
        7, 6, 5, 4, 3, 2, 1,
        2, 3, 4, 5, 6, 7,
        7, 6, 5, 4, 3,
        4, 5, 6, 7,
        7, 6, 5,
        6, 7,
        7
    };

    localparam int ZIGZAG_COL [64] = '{
        0,
        1, 0,
        0, 1, 2,
        3, 2, 1, 0,
        0, 1, 2, 3, 4,
        5, 4, 3, 2, 1, 0,
        0, 1, 2, 3, 4, 5, 6,
        7, 6, 5, 4, 3, 2, 1, 0,
        1, 2, 3, 4, 5, 6, 7,
        7, 6, 5, 4, 3, 2,
        3, 4, 5, 6, 7,
        7, 6, 5, 4,
        5, 6, 7,
        7, 6,
        7
    };

endpackage

// File: rtl/quant_zigzag_if.sv
// ---------------------------------------------------------------------------
// quant_zigzag_if
// Bundles the block-load and coefficient-stream signals of quant_zigzag.
//   start_block   : one-cycle pulse, block data valid this cycle
//   dct_block_in  : signed DCT block, [row][col], COEF_W per entry
//   quant_recip   : unsigned round(2^16/Q) per position, RECIP_W per entry
//   busy          : block accepted and not yet finished
//   coef_out      : quantized coefficient (signed, OUT_W)
//   coef_idx      : zigzag index of coef_out
//   coef_valid    : coef_out / coef_idx / coef_last valid
//   coef_ready    : downstream accepts (handshake = valid & ready)
//   coef_last     : high together with index 63
//   block_done    : one-cycle pulse after the final handshake
// modport master : block source / coefficient sink (testbench side)
// modport slave  : the quantizer itself
// ---------------------------------------------------------------------------
interface quant_zigzag_if
    import quant_zigzag_pkg::*;
#(
    parameter int COEF_W  = QZ_COEF_W,
    parameter int RECIP_W = QZ_RECIP_W,
    parameter int OUT_W   = QZ_OUT_W
) ();

    logic                                 start_block;
    logic signed [7:0][7:0][COEF_W-1:0]   dct_block_in;
    logic        [7:0][7:0][RECIP_W-1:0]  quant_recip;
    logic                                 busy;
    logic signed [OUT_W-1:0]              coef_out;
    logic        [5:0]                    coef_idx;
    logic                                 coef_valid;
    logic                                 coef_ready;
    logic                                 coef_last;
    logic                                 block_done;

    modport master (
        output start_block, dct_block_in, quant_recip, coef_ready,
        input  busy, coef_out, coef_idx, coef_valid, coef_last, block_done
    );

    modport slave (
        input  start_block, dct_block_in, quant_recip, coef_ready,
        output busy, coef_out, coef_idx, coef_valid, coef_last, block_done
    );

endinterface

// File: rtl/quant_zigzag_round_sat.sv
// ---------------------------------------------------------------------------
// quant_round_sat
// Purely combinational: divides a signed fixed-point product by 2^SHIFT,
// rounding halves away from zero, then saturates into a signed OUT_W result.
//   prod_i   : signed product, PROD_W bits
//   result_o : rounded, saturated quotient, OUT_W bits
// ---------------------------------------------------------------------------
module quant_round_sat #(
    parameter int PROD_W = 72,
    parameter int SHIFT  = 40,
    parameter int OUT_W  = 12
) (
    input  logic signed [PROD_W-1:0] prod_i,
    output logic signed [OUT_W-1:0]  result_o
);

    // One extra bit so the magnitude of the most negative product still fits.
    localparam int MAG_W = PROD_W + 1;

    localparam logic [MAG_W-1:0] ONE       = MAG_W'(1);
    localparam logic [MAG_W-1:0] HALF      = ONE << (SHIFT - 1);
    localparam logic [MAG_W-1:0] POS_LIMIT = MAG_W'((1 << (OUT_W - 1)) - 1);
    localparam logic [MAG_W-1:0] NEG_LIMIT = MAG_W'(1 << (OUT_W - 1));

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic             negative;
    logic [MAG_W-1:0] prod_ext;
    logic [MAG_W-1:0] magnitude;
    logic [MAG_W-1:0] rounded_mag;
    logic [MAG_W-1:0] neg_mag;

    // Rounding is done on the magnitude so that adding one half and
    // truncating gives "halves away from zero" for both signs; the sign is
    // reapplied afterwards, and the negative side may reach one step further
    // than the positive side before it clips.
    always_comb begin
        negative    = prod_i[PROD_W-1];
        prod_ext    = {prod_i[PROD_W-1], prod_i};
        magnitude   = negative ? (~prod_ext + ONE) : prod_ext;
        rounded_mag = (magnitude + HALF) >> SHIFT;
        neg_mag     = ~rounded_mag + ONE;
        if (!negative) begin
            result_o = (rounded_mag > POS_LIMIT) ? OUT_MAX : rounded_mag[OUT_W-1:0];
        end else begin
            result_o = (rounded_mag > NEG_LIMIT) ? OUT_MIN : neg_mag[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/quant_zigzag.sv
// ---------------------------------------------------------------------------
// quant_zigzag
// Latches one 8x8 DCT block plus its per-position quantizer reciprocals,
// then streams the 64 quantized coefficients out in JPEG zigzag order over a
// valid/ready handshake.  Datapath: issue (zigzag lookup) -> stage 1
// (full-width multiply register) -> stage 2 (round/saturate output register).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : quant_zigzag_if.slave (block load, coefficient stream, status)
// ---------------------------------------------------------------------------
module quant_zigzag
    import quant_zigzag_pkg::*;
#(
    parameter int COEF_W         = QZ_COEF_W,
    parameter int COEF_FRAC_BITS = QZ_COEF_FRAC_BITS,
    parameter int RECIP_W        = QZ_RECIP_W,
    parameter int OUT_W          = QZ_OUT_W
) (
    input  logic           clk,
    input  logic           rst,
    quant_zigzag_if.slave  bus
);

    localparam int PROD_W = COEF_W + RECIP_W + 1;
    localparam int SHIFT  = COEF_FRAC_BITS + QZ_RECIP_FRAC_BITS;

    // Controller state and latched block.
    qz_state_e                     state_q;
    logic                          busy_q;
    logic                          block_done_q;
    logic [5:0]                    issue_idx_q;
    logic [7:0][7:0][COEF_W-1:0]   coef_blk_q;
    logic [7:0][7:0][RECIP_W-1:0]  recip_blk_q;

    // Stage 1: product register.
    logic                          s1_valid_q;
    logic [5:0]                    s1_idx_q;
    logic                          s1_last_q;
    logic signed [PROD_W-1:0]      s1_prod_q;

    // Stage 2: output register.
    logic                          out_valid_q;
    logic signed [OUT_W-1:0]       out_coef_q;
    logic [5:0]                    out_idx_q;
    logic                          out_last_q;

    logic                          out_adv;
    logic                          s1_adv;
    logic                          issue;
    logic                          final_handshake;
    logic [2:0]                    zz_row;
    logic [2:0]                    zz_col;
    logic signed [PROD_W-1:0]      coef_ext;
    logic signed [PROD_W-1:0]      recip_ext;
    logic signed [PROD_W-1:0]      prod_d;
    logic signed [OUT_W-1:0]       out_coef_d;

    // A stage may load whenever it is empty or the stage after it is
    // moving, so a low coef_ready freezes the output register, stage 1 and
    // the issue counter together and nothing is dropped or repeated.
    assign out_adv         = !out_valid_q || bus.coef_ready;
    assign s1_adv          = !s1_valid_q || out_adv;
    assign issue           = (state_q == RUN) && s1_adv;
    assign final_handshake = out_valid_q && bus.coef_ready && out_last_q;

    assign zz_row = 3'(ZIGZAG_ROW[issue_idx_q]);
    assign zz_col = 3'(ZIGZAG_COL[issue_idx_q]);

    // Both operands are widened to the full product width before the
    // multiply (coefficient sign-extended, reciprocal zero-extended), so the
    // product is exact and no bits are lost before rounding.
    always_comb begin
        coef_ext  = PROD_W'($signed(coef_blk_q[zz_row][zz_col]));
        recip_ext = PROD_W'({1'b0, recip_blk_q[zz_row][zz_col]});
        prod_d    = coef_ext * recip_ext;
    end

    // Controller: IDLE waits for a block, RUN issues zigzag indices 0..63
    // into the pipeline, DRAIN waits for index 63 to be taken downstream.
    // start_block is only looked at in IDLE, so a pulse while busy cannot
    // disturb the latched block.  The idle transition, busy drop and
    // block_done pulse all land on the cycle after the final handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            block_done_q <= 1'b0;
            issue_idx_q  <= 6'd0;
        end else begin
            block_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_block) begin
                        coef_blk_q  <= bus.dct_block_in;
                        recip_blk_q <= bus.quant_recip;
                        issue_idx_q <= 6'd0;
                        busy_q      <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (issue_idx_q == 6'd63) begin
                            state_q <= DRAIN;
                        end else begin
                            issue_idx_q <= issue_idx_q + 6'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (final_handshake) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        block_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    quant_round_sat #(
        .PROD_W (PROD_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) u_round_sat (
        .prod_i   (s1_prod_q),
        .result_o (out_coef_d)
    );

    // Two-stage datapath.  Stage 1 captures the exact product of the issued
    // position; stage 2 captures its rounded/saturated value.  Data fields
    // only load alongside a valid entry, so a held output keeps its value,
    // while coef_last is cleared whenever an empty slot moves in.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= 6'd0;
            s1_last_q   <= 1'b0;
            s1_prod_q   <= '0;
            out_valid_q <= 1'b0;
            out_coef_q  <= '0;
            out_idx_q   <= 6'd0;
            out_last_q  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= issue;
                if (issue) begin
                    s1_prod_q <= prod_d;
                    s1_idx_q  <= issue_idx_q;
                    s1_last_q <= (issue_idx_q == 6'd63);
                end
            end
            if (out_adv) begin
                out_valid_q <= s1_valid_q;
                out_last_q  <= s1_valid_q && s1_last_q;
                if (s1_valid_q) begin
                    out_coef_q <= out_coef_d;
                    out_idx_q  <= s1_idx_q;
                end
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.block_done = block_done_q;
    assign bus.coef_valid = out_valid_q;
    assign bus.coef_out   = out_coef_q;
    assign bus.coef_idx   = out_idx_q;
    assign bus.coef_last  = out_last_q;

endmodule

// File: tb/tb_quant_zigzag.sv
// ---------------------------------------------------------------------------
// tb_quant_zigzag
// Directed block sequence with randomized data for quant_zigzag.  Expected
// coefficients come from an arithmetic reference (exact product, rounded
// division, clamp) applied in a zigzag order generated by walking the
// anti-diagonals of the block.
// ---------------------------------------------------------------------------
module tb_quant_zigzag;

    localparam int COEF_W         = 54;
    localparam int COEF_FRAC_BITS = 24;
    localparam int RECIP_W        = 17;
    localparam int OUT_W          = 12;

    logic clk = 1'b0;
    logic rst;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    quant_zigzag_if #(.COEF_W(COEF_W), .RECIP_W(RECIP_W), .OUT_W(OUT_W)) bus ();

    quant_zigzag #(
        .COEF_W         (COEF_W),
        .COEF_FRAC_BITS (COEF_FRAC_BITS),
        .RECIP_W        (RECIP_W),
        .OUT_W          (OUT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic signed [COEF_W-1:0] stimCoef  [8][8];
    logic        [RECIP_W-1:0] stimRecip [8][8];
    int expOut [64];
    int zzRow  [64];
    int zzCol  [64];
    int gotIdx [$];
    int firstValidCycle, doneCycle, doneCount, lastHsCycle, idleValid, busyAtDone, lastCycle;

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Zigzag order: walk anti-diagonals d = row + col, alternating direction.
    task automatic buildZigzag();
        int k = 0;
        for (int d = 0; d < 15; d++) begin
            int lo = (d > 7) ? d - 7 : 0;
            int hi = (d < 7) ? d : 7;
            if (d % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zzRow[k] = r; zzCol[k] = d - r; k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zzRow[k] = r; zzCol[k] = d - r; k++;
                end
            end
        end
    endtask

    // round(c*q / 2^40) with halves away from zero, then clamp to OUT_W.
    function automatic int quantRef(input logic signed [COEF_W-1:0] c,
                                    input logic [RECIP_W-1:0] q);
        logic signed [127:0] p, unit, num, res, hi, lo;
        p    = 128'(c) * $signed(128'(q));
        unit = 128'sd1 <<< (COEF_FRAC_BITS + 16);
        num  = (p < 0) ? (p + p - unit) : (p + p + unit);
        res  = num / (unit + unit);
        hi   = (128'sd1 <<< (OUT_W - 1)) - 128'sd1;
        lo   = -(128'sd1 <<< (OUT_W - 1));
        if (res > hi) res = hi;
        if (res < lo) res = lo;
        return int'(res);
    endfunction

    task automatic fillConst(input longint c, input int q);
        for (int r = 0; r < 8; r++)
            for (int cc = 0; cc < 8; cc++) begin
                stimCoef[r][cc]  = COEF_W'(c);
                stimRecip[r][cc] = RECIP_W'(q);
            end
    endtask

    task automatic fillRandom();
        longint v;
        for (int r = 0; r < 8; r++)
            for (int cc = 0; cc < 8; cc++) begin
                v = longint'({$urandom, $urandom});
                v = v >>> 28;
                stimCoef[r][cc]  = COEF_W'(v);
                stimRecip[r][cc] = RECIP_W'($urandom_range(0, 131071));
            end
    endtask

    // Drive the block with a start pulse and compute its expected stream.
    task automatic applyStimulus();
        for (int r = 0; r < 8; r++)
            for (int cc = 0; cc < 8; cc++) begin
                bus.dct_block_in[r][cc] = stimCoef[r][cc];
                bus.quant_recip[r][cc]  = stimRecip[r][cc];
            end
        for (int k = 0; k < 64; k++)
            expOut[k] = quantRef(stimCoef[zzRow[k]][zzCol[k]], stimRecip[zzRow[k]][zzCol[k]]);
        bus.start_block = 1'b1;
    endtask

    // Runs one block starting at the current negedge (cycle 0 = start).
    // mode 0: ready always 1; mode 1: ready held low 5 cycles once stallAt
    // is presented, random afterwards.  resetAt >= 0 pulses rst when that
    // index is presented and then watches 10 quiet cycles.
    task automatic runBlock(input int mode, input int stallAt, input int resetAt,
                            input bit injectStart);
        int c = 0;
        int n;
        int stallLeft = 0;
        int quietLeft = 0;
        bit stallDone = 1'b0;
        bit resetDone = 1'b0;
        gotIdx.delete();
        firstValidCycle = -1; doneCycle = -1; doneCount = 0;
        lastHsCycle = -1; idleValid = 0; busyAtDone = -1;
        applyStimulus();
        bus.coef_ready = 1'b1;
        while (1) begin
            @(negedge clk);
            c++;
            bus.start_block = 1'b0;
            if (rst) rst = 1'b0;
            if (c > 1000) begin
                checkOutput("blockTimeout", doneCount + (resetDone ? 1 : 0), 1);
                break;
            end
            if (bus.coef_valid && firstValidCycle < 0) firstValidCycle = c;
            if (!bus.busy && bus.coef_valid) idleValid++;
            if (bus.coef_valid) begin
                n = gotIdx.size();
                if (n > 63) begin
                    checkOutput("extraValid", n, 63);
                end else begin
                    checkOutput("coefIdx", bus.coef_idx, n);
                    checkOutput("coefOut", bus.coef_out, expOut[n]);
                    checkOutput("coefLast", bus.coef_last, (n == 63));
                end
            end
            if (bus.block_done) begin
                doneCount++;
                if (doneCycle < 0) begin
                    doneCycle = c;
                    busyAtDone = bus.busy;
                end
            end
            if (resetDone) begin
                quietLeft--;
                if (quietLeft == 0) break;
                continue;
            end
            if (resetAt >= 0 && bus.coef_valid && int'(bus.coef_idx) == resetAt) begin
                rst = 1'b1;
                bus.coef_ready = 1'b0;
                resetDone = 1'b1;
                quietLeft = 10;
                continue;
            end
            if (mode == 1) begin
                if (!stallDone && bus.coef_valid && int'(bus.coef_idx) == stallAt) begin
                    stallLeft = 5;
                    stallDone = 1'b1;
                end
                if (stallLeft > 0) begin
                    bus.coef_ready = 1'b0;
                    stallLeft--;
                end else if (stallDone) begin
                    bus.coef_ready = 1'($urandom_range(0, 1));
                end else begin
                    bus.coef_ready = 1'b1;
                end
            end else begin
                bus.coef_ready = 1'b1;
            end
            if (bus.coef_valid && bus.coef_ready) begin
                gotIdx.push_back(int'(bus.coef_idx));
                if (bus.coef_last) lastHsCycle = c;
            end
            if (injectStart && c == 20) begin
                bus.dct_block_in = '1;
                bus.quant_recip  = '1;
                bus.start_block  = 1'b1;
            end
            if (doneCount > 0) break;
        end
        lastCycle = c;
    endtask

    task automatic checkBlock(input string tag, input bit consecutive);
        checkOutput({tag, ".count"}, gotIdx.size(), 64);
        checkOutput({tag, ".firstValid"}, firstValidCycle, 3);
        checkOutput({tag, ".doneCount"}, doneCount, 1);
        checkOutput({tag, ".doneAfterLast"}, doneCycle - lastHsCycle, 1);
        checkOutput({tag, ".busyAtDone"}, busyAtDone, 0);
        checkOutput({tag, ".idleValid"}, idleValid, 0);
        if (consecutive) checkOutput({tag, ".lastHsCycle"}, lastHsCycle, 66);
    endtask

    // Watchdog in case a wait outside runBlock ever hangs.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        buildZigzag();
        rst = 1'b1;
        bus.start_block  = 1'b0;
        bus.coef_ready   = 1'b1;
        bus.dct_block_in = '0;
        bus.quant_recip  = '0;
        repeat (2) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst.busy", bus.busy, 0);
        checkOutput("rst.valid", bus.coef_valid, 0);
        checkOutput("rst.last", bus.coef_last, 0);
        checkOutput("rst.done", bus.block_done, 0);
        checkOutput("rst.out", bus.coef_out, 0);
        checkOutput("rst.idx", bus.coef_idx, 0);

        $display("[TB] reset has priority over start_block");
        fillConst(longint'(16) <<< 24, 4096);
        applyStimulus();
        @(negedge clk);
        rst = 1'b0;
        bus.start_block = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("rstPrio.busy", bus.busy, 0);
            checkOutput("rstPrio.valid", bus.coef_valid, 0);
        end

        $display("[TB] constant block, expect all ones");
        fillConst(longint'(16) <<< 24, 4096);
        runBlock(0, -1, -1, 1'b0);
        checkBlock("const", 1'b1);

        $display("[TB] ramp block started in the block_done cycle");
        for (int r = 0; r < 8; r++)
            for (int cc = 0; cc < 8; cc++) begin
                stimCoef[r][cc]  = COEF_W'(longint'(8 * r + cc) <<< 24);
                stimRecip[r][cc] = RECIP_W'(65536);
            end
        runBlock(0, -1, -1, 1'b0);
        checkBlock("ramp", 1'b1);

        $display("[TB] rounding and saturation corners");
        fillConst(0, 65536);
        stimCoef[0][0] = COEF_W'(longint'(5) <<< 23);
        stimCoef[0][1] = COEF_W'(-(longint'(5) <<< 23));
        stimCoef[1][0] = COEF_W'(longint'(5000) <<< 24);
        stimCoef[2][0] = COEF_W'(-(longint'(5000) <<< 24));
        runBlock(0, -1, -1, 1'b0);
        checkBlock("corners", 1'b1);
        checkOutput("corners.idx0", expOut[0], 3);
        checkOutput("corners.idx1", expOut[1], -3);

        $display("[TB] random block, stall at idx 10, random ready, start while busy");
        fillRandom();
        runBlock(1, 10, -1, 1'b1);
        checkBlock("stall", 1'b0);

        $display("[TB] random block, reset at idx 30");
        fillRandom();
        runBlock(0, -1, 30, 1'b0);
        checkOutput("reset.partialCount", gotIdx.size(), 30);
        checkOutput("reset.doneCount", doneCount, 0);
        checkOutput("reset.idleValid", idleValid, 0);
        checkOutput("reset.busy", bus.busy, 0);
        checkOutput("reset.valid", bus.coef_valid, 0);

        $display("[TB] random block after reset, random ready, start while busy");
        fillRandom();
        runBlock(1, 10, -1, 1'b1);
        checkBlock("postReset", 1'b0);

        @(negedge clk);
        checkOutput("tail.done", bus.block_done, 0);
        checkOutput("tail.busy", bus.busy, 0);
        checkOutput("tail.valid", bus.coef_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
